// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// -----------------
// Shares one integer ALU between two requesters. Port 0 is the core issue
// path coming out of the decoder. Port 1 is the debug/ILA operation injector.
// One operation runs at a time: it is granted, issued, waited on (with a
// timeout), and its response is routed back to whichever port owns it.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   r0_* / r1_*            per-port request (valid/ready/op/s1/s2) and
//                          response handshake (rsp_valid/rsp_ready)
//   rsp_res, rsp_negative, shared response payload; it is only meaningful
//   rsp_zero, rsp_err      while the owner's rsp_valid is high
//   alu_start, alu_op,     registered command to the ALU
//   alu_s1, alu_s2
//   alu_done, alu_res,     ALU completion and result
//   alu_status_negative,
//   alu_status_zero
//   busy                   high whenever an operation is in flight
//   owner                  port currently (or last) granted
//   ops_done               completed responses, including timeouts; wraps

module alu_share_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int OP_W    = 5,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic [OP_W-1:0] r0_op,
  input  logic [XLEN-1:0] r0_s1,
  input  logic [XLEN-1:0] r0_s2,
  output logic            r0_rsp_valid,
  input  logic            r0_rsp_ready,

  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic [OP_W-1:0] r1_op,
  input  logic [XLEN-1:0] r1_s1,
  input  logic [XLEN-1:0] r1_s2,
  output logic            r1_rsp_valid,
  input  logic            r1_rsp_ready,

  output logic [XLEN-1:0] rsp_res,
  output logic            rsp_negative,
  output logic            rsp_zero,
  output logic            rsp_err,

  output logic            alu_start,
  output logic [OP_W-1:0] alu_op,
  output logic [XLEN-1:0] alu_s1,
  output logic [XLEN-1:0] alu_s2,
  input  logic            alu_done,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_status_negative,
  input  logic            alu_status_zero,

  output logic            busy,
  output logic            owner,
  output logic [31:0]     ops_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // WAIT gives up after TIMEOUT cycles: the abort happens in the cycle where
  // the counter already holds TIMEOUT-1 and would reach TIMEOUT.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic       last_grant;
  logic       winner;
  logic       accept;
  logic       owner_rsp_ready;
  logic [7:0] tmo_cnt;

  // Round-robin pick. A lone requester always wins. On a tie the port that
  // was not granted last time wins. last_grant resets to 1, so port 0 takes
  // the first tie after reset.
  always_comb begin
    winner = 1'b0;
    if (r0_valid && r1_valid) begin
      winner = ~last_grant;
    end else if (r1_valid) begin
      winner = 1'b1;
    end
  end

  assign accept          = (state == IDLE) && (r0_valid || r1_valid);
  assign owner_rsp_ready = owner ? r1_rsp_ready : r0_rsp_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. ISSUE already samples alu_done, so a single-cycle ALU
  // skips WAIT entirely.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = ISSUE;
      ISSUE: state_next = alu_done ? RESP : WAIT;
      WAIT:  if (alu_done || (tmo_cnt == TMO_LAST)) state_next = RESP;
      RESP:  if (owner_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode. Ready is combinational so a request is accepted in the
  // same cycle the arbiter sees it in IDLE.
  always_comb begin
    r0_ready     = (state == IDLE) && r0_valid && (winner == 1'b0);
    r1_ready     = (state == IDLE) && r1_valid && (winner == 1'b1);
    alu_start    = (state == ISSUE);
    busy         = (state != IDLE);
    r0_rsp_valid = (state == RESP) && (owner == 1'b0);
    r1_rsp_valid = (state == RESP) && (owner == 1'b1);
  end

  // Datapath. The ALU command registers are written only on accept, so they
  // stay stable through ISSUE and WAIT. The response registers are written
  // only when leaving ISSUE or WAIT, so they stay stable through RESP.
  // An alu_done that arrives in IDLE or RESP is therefore ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_op       <= '0;
      alu_s1       <= '0;
      alu_s2       <= '0;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      tmo_cnt      <= '0;
      rsp_res      <= '0;
      rsp_negative <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_err      <= 1'b0;
      ops_done     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_op     <= winner ? r1_op : r0_op;
            alu_s1     <= winner ? r1_s1 : r0_s1;
            alu_s2     <= winner ? r1_s2 : r0_s2;
            owner      <= winner;
            last_grant <= winner;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          if (alu_done) begin
            rsp_res      <= alu_res;
            rsp_negative <= alu_status_negative;
            rsp_zero     <= alu_status_zero;
            rsp_err      <= 1'b0;
          end
        end
        WAIT: begin
          if (alu_done) begin
            rsp_res      <= alu_res;
            rsp_negative <= alu_status_negative;
            rsp_zero     <= alu_status_zero;
            rsp_err      <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
            if (tmo_cnt == TMO_LAST) begin
              rsp_res      <= '0;
              rsp_negative <= 1'b0;
              rsp_zero     <= 1'b0;
              rsp_err      <= 1'b1;
            end
          end
        end
        RESP: begin
          if (owner_rsp_ready) begin
            ops_done <= ops_done + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// --------------------
// Directed testbench for alu_share_arbiter. The bench plays the role of the
// ALU itself, driving alu_done and the result by hand.
// Inputs change 2 time units after each rising edge. Outputs are checked one
// time unit later, well clear of the next edge.

module tb_alu_share_arbiter;

  localparam int OP_W    = 5;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
  logic [OP_W-1:0] r0_op;
  logic [XLEN-1:0] r0_s1, r0_s2;
  logic            r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
  logic [OP_W-1:0] r1_op;
  logic [XLEN-1:0] r1_s1, r1_s2;
  logic [XLEN-1:0] rsp_res;
  logic            rsp_negative, rsp_zero, rsp_err;
  logic            alu_start;
  logic [OP_W-1:0] alu_op;
  logic [XLEN-1:0] alu_s1, alu_s2;
  logic            alu_done;
  logic [XLEN-1:0] alu_res;
  logic            alu_status_negative, alu_status_zero;
  logic            busy, owner;
  logic [31:0]     ops_done;

  int n_cmp   = 0;
  int n_bad   = 0;
  int exp_ops = 0;

  alu_share_arbiter #(.TIMEOUT(TIMEOUT), .OP_W(OP_W), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_s1(r0_s1),
    .r0_s2(r0_s2), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_s1(r1_s1),
    .r1_s2(r1_s2), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .rsp_res(rsp_res), .rsp_negative(rsp_negative), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .alu_start(alu_start), .alu_op(alu_op),
    .alu_s1(alu_s1), .alu_s2(alu_s2), .alu_done(alu_done), .alu_res(alu_res),
    .alu_status_negative(alu_status_negative),
    .alu_status_zero(alu_status_zero),
    .busy(busy), .owner(owner), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  // Hard stop in case something never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no end, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [OP_W-1:0] op0,
                               input logic [XLEN-1:0] a0, input logic [XLEN-1:0] b0,
                               input logic v1, input logic [OP_W-1:0] op1,
                               input logic [XLEN-1:0] a1, input logic [XLEN-1:0] b1);
    r0_valid = v0; r0_op = op0; r0_s1 = a0; r0_s2 = b0;
    r1_valid = v1; r1_op = op1; r1_s1 = a1; r1_s2 = b1;
  endtask

  task automatic aluDrive(input logic done, input logic [XLEN-1:0] res,
                          input logic neg, input logic zero);
    alu_done = done; alu_res = res;
    alu_status_negative = neg; alu_status_zero = zero;
  endtask

  task automatic doReset;
    reset = 1'b1;
    applyStimulus(0, '0, '0, '0, 0, '0, '0, '0);
    aluDrive(0, '0, 0, 0);
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    exp_ops = 0;
  endtask

  // One tied round-robin transaction with a single-cycle ALU. Both ports
  // keep their requests up, and both rsp_ready lines are raised so that the
  // non-owner's ready is shown to be ignored.
  task automatic runTie(input logic exp_port, input int idx);
    logic [OP_W-1:0] op_e;
    logic [XLEN-1:0] s1_e, s2_e, res_e;
    logic            zero_e;
    op_e   = exp_port ? OP_W'(idx + 9) : OP_W'(idx + 1);
    s1_e   = exp_port ? XLEN'(100 + idx) : XLEN'(idx);
    s2_e   = exp_port ? XLEN'(7) : XLEN'(10 * idx + 1);
    res_e  = s1_e + s2_e;
    zero_e = (idx == 2);
    applyStimulus(1, OP_W'(idx + 1), XLEN'(idx), XLEN'(10 * idx + 1),
                  1, OP_W'(idx + 9), XLEN'(100 + idx), XLEN'(7));
    settle;
    checkOutput($sformatf("tie%0d_r0_ready", idx), 32'(r0_ready), 32'(!exp_port));
    checkOutput($sformatf("tie%0d_r1_ready", idx), 32'(r1_ready), 32'(exp_port));
    nextCycle;
    aluDrive(1, res_e, 0, zero_e);
    settle;
    checkOutput($sformatf("tie%0d_owner", idx), 32'(owner), 32'(exp_port));
    checkOutput($sformatf("tie%0d_alu_op", idx), 32'(alu_op), 32'(op_e));
    checkOutput($sformatf("tie%0d_alu_s1", idx), alu_s1, s1_e);
    checkOutput($sformatf("tie%0d_alu_s2", idx), alu_s2, s2_e);
    nextCycle;
    aluDrive(0, '0, 0, 0);
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    settle;
    checkOutput($sformatf("tie%0d_r0_rsp_valid", idx), 32'(r0_rsp_valid), 32'(!exp_port));
    checkOutput($sformatf("tie%0d_r1_rsp_valid", idx), 32'(r1_rsp_valid), 32'(exp_port));
    checkOutput($sformatf("tie%0d_rsp_res", idx), rsp_res, res_e);
    checkOutput($sformatf("tie%0d_rsp_zero", idx), 32'(rsp_zero), 32'(zero_e));
    nextCycle;
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
    exp_ops++;
    settle;
    checkOutput($sformatf("tie%0d_ops_done", idx), ops_done, 32'(exp_ops));
  endtask

  initial begin
    int n;
    logic [XLEN-1:0] held_res;

    // Reset values.
    reset = 1'b1;
    applyStimulus(0, '0, '0, '0, 0, '0, '0, '0);
    aluDrive(0, '0, 0, 0);
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_alu_start", 32'(alu_start), 32'd0);
    checkOutput("rst_owner", 32'(owner), 32'd0);
    checkOutput("rst_ops_done", ops_done, 32'd0);
    checkOutput("rst_alu_s1", alu_s1, 32'd0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Single request on port 0 with a single-cycle ALU.
    $display("[TB] single request");
    applyStimulus(1, 5'd0, 32'd5, 32'd7, 0, '0, '0, '0);
    settle;
    checkOutput("t1_r0_ready", 32'(r0_ready), 32'd1);
    checkOutput("t1_r1_ready", 32'(r1_ready), 32'd0);
    checkOutput("t1_start_T", 32'(alu_start), 32'd0);
    nextCycle;
    applyStimulus(0, '0, '0, '0, 0, '0, '0, '0);
    aluDrive(1, 32'd12, 0, 0);
    settle;
    checkOutput("t1_start_T1", 32'(alu_start), 32'd1);
    checkOutput("t1_alu_s1", alu_s1, 32'd5);
    checkOutput("t1_alu_s2", alu_s2, 32'd7);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    nextCycle;
    aluDrive(0, '0, 0, 0);
    settle;
    checkOutput("t1_start_T2", 32'(alu_start), 32'd0);
    checkOutput("t1_r0_rsp_valid", 32'(r0_rsp_valid), 32'd1);
    checkOutput("t1_r1_rsp_valid", 32'(r1_rsp_valid), 32'd0);
    checkOutput("t1_rsp_res", rsp_res, 32'd12);
    checkOutput("t1_rsp_zero", 32'(rsp_zero), 32'd0);
    checkOutput("t1_rsp_neg", 32'(rsp_negative), 32'd0);
    checkOutput("t1_rsp_err", 32'(rsp_err), 32'd0);
    r0_rsp_ready = 1'b1;
    nextCycle;
    r0_rsp_ready = 1'b0;
    settle;
    checkOutput("t1_ops_done", ops_done, 32'd1);
    checkOutput("t1_idle", 32'(busy), 32'd0);

    // Round-robin with both ports requesting; start from reset so port 0 wins first.
    $display("[TB] round robin");
    doReset;
    runTie(1'b0, 0);
    runTie(1'b1, 1);
    runTie(1'b0, 2);
    runTie(1'b1, 3);
    applyStimulus(0, '0, '0, '0, 0, '0, '0, '0);

    // Slow ALU: done arrives five cycles after start.
    $display("[TB] slow alu");
    applyStimulus(1, 5'd4, 32'hDEAD_0001, 32'h0000_BEEF, 0, '0, '0, '0);
    settle;
    checkOutput("t3_r0_ready", 32'(r0_ready), 32'd1);
    nextCycle;
    applyStimulus(0, '0, '0, '0, 0, '0, '0, '0);
    settle;
    checkOutput("t3_start", 32'(alu_start), 32'd1);
    for (int i = 1; i < 5; i++) begin
      nextCycle;
      settle;
      checkOutput($sformatf("t3_s1_c%0d", i), alu_s1, 32'hDEAD_0001);
      checkOutput($sformatf("t3_s2_c%0d", i), alu_s2, 32'h0000_BEEF);
      checkOutput($sformatf("t3_start_c%0d", i), 32'(alu_start), 32'd0);
      checkOutput($sformatf("t3_rspv_c%0d", i), 32'(r0_rsp_valid), 32'd0);
    end
    nextCycle;
    aluDrive(1, 32'hFFFF_FFF0, 1, 0);
    settle;
    checkOutput("t3_s1_done", alu_s1, 32'hDEAD_0001);
    nextCycle;
    aluDrive(0, '0, 0, 0);
    settle;
    checkOutput("t3_rsp_valid", 32'(r0_rsp_valid), 32'd1);
    checkOutput("t3_rsp_res", rsp_res, 32'hFFFF_FFF0);
    checkOutput("t3_rsp_neg", 32'(rsp_negative), 32'd1);
    checkOutput("t3_rsp_err", 32'(rsp_err), 32'd0);
    r0_rsp_ready = 1'b1;
    nextCycle;
    r0_rsp_ready = 1'b0;
    exp_ops++;
    settle;
    checkOutput("t3_ops_done", ops_done, 32'(exp_ops));

    // Timeout: no alu_done at all. ISSUE plus TIMEOUT WAIT cycles, then RESP.
    $display("[TB] timeout");
    applyStimulus(0, '0, '0, '0, 1, 5'd3, 32'd9, 32'd4);
    settle;
    checkOutput("t4_r1_ready", 32'(r1_ready), 32'd1);
    nextCycle;
    applyStimulus(0, '0, '0, '0, 0, '0, '0, '0);
    settle;
    checkOutput("t4_start", 32'(alu_start), 32'd1);
    n = 0;
    while (!r1_rsp_valid && n < 40) begin
      nextCycle;
      n++;
    end
    checkOutput("t4_tmo_cycles", 32'(n), 32'(TIMEOUT + 1));
    checkOutput("t4_rsp_err", 32'(rsp_err), 32'd1);
    checkOutput("t4_rsp_res", rsp_res, 32'd0);
    checkOutput("t4_rsp_neg", 32'(rsp_negative), 32'd0);
    checkOutput("t4_rsp_zero", 32'(rsp_zero), 32'd0);
    aluDrive(1, 32'h1234, 1, 1);
    nextCycle;
    aluDrive(0, '0, 0, 0);
    settle;
    checkOutput("t4_late_res", rsp_res, 32'd0);
    checkOutput("t4_late_err", 32'(rsp_err), 32'd1);
    checkOutput("t4_late_valid", 32'(r1_rsp_valid), 32'd1);
    r1_rsp_ready = 1'b1;
    nextCycle;
    r1_rsp_ready = 1'b0;
    exp_ops++;
    aluDrive(1, 32'h5678, 0, 1);
    settle;
    checkOutput("t4_ops_done", ops_done, 32'(exp_ops));
    nextCycle;
    aluDrive(0, '0, 0, 0);
    settle;
    checkOutput("t4_idle_done_ignored", 32'(busy), 32'd0);

    // Response backpressure on port 1 while port 0 waits.
    $display("[TB] backpressure");
    applyStimulus(0, '0, '0, '0, 1, 5'd2, 32'd40, 32'd2);
    settle;
    checkOutput("t5_r1_ready", 32'(r1_ready), 32'd1);
    nextCycle;
    applyStimulus(1, 5'd6, 32'd3, 32'd3, 0, '0, '0, '0);
    aluDrive(1, 32'd38, 0, 0);
    nextCycle;
    aluDrive(0, '0, 0, 0);
    r0_rsp_ready = 1'b1;
    held_res = 32'd38;
    for (int i = 0; i < 3; i++) begin
      settle;
      checkOutput($sformatf("t5_res_c%0d", i), rsp_res, held_res);
      checkOutput($sformatf("t5_busy_c%0d", i), 32'(busy), 32'd1);
      checkOutput($sformatf("t5_r0_ready_c%0d", i), 32'(r0_ready), 32'd0);
      checkOutput($sformatf("t5_r1_rspv_c%0d", i), 32'(r1_rsp_valid), 32'd1);
      nextCycle;
    end
    r0_rsp_ready = 1'b0;
    r1_rsp_ready = 1'b1;
    nextCycle;
    r1_rsp_ready = 1'b0;
    exp_ops++;
    settle;
    checkOutput("t5_r0_ready_idle", 32'(r0_ready), 32'd1);
    checkOutput("t5_ops_done", ops_done, 32'(exp_ops));
    nextCycle;
    applyStimulus(0, '0, '0, '0, 0, '0, '0, '0);
    aluDrive(1, 32'd6, 0, 0);
    nextCycle;
    aluDrive(0, '0, 0, 0);
    r0_rsp_ready = 1'b1;
    settle;
    checkOutput("t5_r0_rsp_res", rsp_res, 32'd6);
    nextCycle;
    r0_rsp_ready = 1'b0;

    // Reset asserted in WAIT; port 0 owned the last grant, so a surviving
    // last_grant would hand the next tie to port 1.
    $display("[TB] reset in wait");
    applyStimulus(1, 5'd1, 32'd77, 32'd88, 0, '0, '0, '0);
    nextCycle;
    applyStimulus(0, '0, '0, '0, 0, '0, '0, '0);
    nextCycle;
    settle;
    checkOutput("t6_in_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    settle;
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_alu_s1", alu_s1, 32'd0);
    checkOutput("t6_rst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("t6_rst_ops_done", ops_done, 32'd0);
    checkOutput("t6_rst_alu_start", 32'(alu_start), 32'd0);
    nextCycle;
    reset = 1'b0;
    exp_ops = 0;
    for (int i = 0; i < 2; i++) begin
      settle;
      checkOutput($sformatf("t6_no_rsp0_c%0d", i), 32'(r0_rsp_valid), 32'd0);
      checkOutput($sformatf("t6_no_rsp1_c%0d", i), 32'(r1_rsp_valid), 32'd0);
      nextCycle;
    end
    applyStimulus(1, 5'd2, 32'd1, 32'd1, 1, 5'd3, 32'd2, 32'd2);
    settle;
    checkOutput("t6_tie_r0_ready", 32'(r0_ready), 32'd1);
    checkOutput("t6_tie_r1_ready", 32'(r1_ready), 32'd0);
    applyStimulus(0, '0, '0, '0, 0, '0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
